// File: rtl/decode_regread_stage.sv
// decode_regread_stage
//
// Decode + register-read pipeline stage. Splits a 32-bit RV instruction into
// its fields and reads both source operands from an internal NREGS x XLEN
// register file. The result is held in a valid/ready output register for the
// execute stage. A writeback port updates the register file and can forward
// its data to the same-cycle read path. A per-register busy scoreboard stalls
// RAW and WAW hazards and is cleared by flush.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   flush                synchronous: drop the held instruction, clear busy bits
//   in_valid/in_ready    instruction input handshake
//   instruction          32-bit instruction word
//   wb_valid/wb_rd/wb_data  writeback port
//   out_valid/out_ready  output register handshake
//   out_opcode..out_funct7  decoded fields
//   out_rs1_data/out_rs2_data  operands
//   out_writes_rd        instruction will write back to out_rd
//   dbg_busy             scoreboard contents, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. A producer holding valid=1 keeps its data stable until the transfer. Input
// ready is combinational and never depends on in_valid. The output register
// holds its contents stable while out_valid=1 and out_ready=0.

module decode_regread_stage #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_rs1_data,
  output logic [XLEN-1:0]  out_rs2_data,
  output logic             out_writes_rd,
  output logic [NREGS-1:0] dbg_busy
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Field decode
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  logic uses_rs1;
  logic uses_rs2;
  logic writes_rd;

  assign uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                       (opcode == OPC_JAL));
  assign uses_rs2  = (opcode == OPC_OP) || (opcode == OPC_OP32) ||
                     (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  assign writes_rd = (rd != 5'd0) && (opcode != OPC_STORE) &&
                     (opcode != OPC_BRANCH);

  // A same-cycle writeback to a register both supplies its value and
  // releases its busy bit, so a waiting consumer can go in that cycle.
  logic clr_rs1;
  logic clr_rs2;
  logic clr_rd;

  assign clr_rs1 = BYPASS_EN && wb_valid && (wb_rd == rs1);
  assign clr_rs2 = BYPASS_EN && wb_valid && (wb_rd == rs2);
  assign clr_rd  = BYPASS_EN && wb_valid && (wb_rd == rd);

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  always_comb begin
    rs1_data = regs[rs1];
    if (rs1 == 5'd0)  rs1_data = '0;
    else if (clr_rs1) rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2];
    if (rs2 == 5'd0)  rs2_data = '0;
    else if (clr_rs2) rs2_data = wb_data;
  end

  logic hazard;
  logic accept;

  assign hazard = (uses_rs1  && busy[rs1] && !clr_rs1) ||
                  (uses_rs2  && busy[rs2] && !clr_rs2) ||
                  (writes_rd && busy[rd]  && !clr_rd);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Scoreboard next state: writeback clears first, a new writer then sets,
  // so set wins when both hit the same index. Flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (accept && writes_rd) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign dbg_busy = busy;

  // Register file; the write still happens during flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Output pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_opcode    <= '0;
      out_rd        <= '0;
      out_funct3    <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_funct7    <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_writes_rd <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_opcode    <= opcode;
      out_rd        <= rd;
      out_funct3    <= funct3;
      out_rs1       <= rs1;
      out_rs2       <= rs2;
      out_funct7    <= funct7;
      out_rs1_data  <= rs1_data;
      out_rs2_data  <= rs2_data;
      out_writes_rd <= writes_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/decode_regread_stage.md
Name: decode_regread_stage

Overview:
- Parametrised successor to the parser + register-file top level.
- Decodes a 32-bit RV instruction, reads its source operands from an internal NREGS x XLEN register file, and presents the result in a valid/ready pipeline register to the execute stage.
- Adds a writeback port with write-to-read bypass, plus a per-register busy scoreboard that stalls RAW/WAW hazards and can be flushed.

Parameters:
- XLEN, 64, register and data width in bits.
- NREGS, 32, number of architectural registers; index width is clog2(NREGS), 5 at default.
- BYPASS_EN, 1, 1 = same-cycle writeback data forwarded to the read path and used to clear the busy check; 0 = no forwarding.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drop the held instruction and clear the scoreboard.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  32  RV32/RV64 instruction word.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  5  writeback destination index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  execute stage consumes the output.
- out_opcode  out  7  instruction[6:0].
- out_rd  out  5  instruction[11:7].
- out_funct3  out  3  instruction[14:12].
- out_rs1  out  5  instruction[19:15].
- out_rs2  out  5  instruction[24:20].
- out_funct7  out  7  instruction[31:25].
- out_rs1_data  out  XLEN  operand 1.
- out_rs2_data  out  XLEN  operand 2.
- out_writes_rd  out  1  instruction will write back to out_rd.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers, all busy bits, out_valid and all out_* outputs go to 0.
  - in_ready is combinational and therefore 1 while in reset is released with no hazard present.
- Register file:
  - x0 always reads 0; writes to index 0 are ignored.
  - A write occurs on a clk edge when wb_valid=1 and wb_rd!=0.
  - The write is performed even during flush.
- Field decode: combinational from instruction, per the Ports list.
- Source usage:
  - uses_rs1 = 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); 1 otherwise.
  - uses_rs2 = 1 only for OP (0110011), OP-32 (0111011), STORE (0100011) and BRANCH (1100011).
- writes_rd = (rd!=0) AND opcode not STORE and not BRANCH.
- Read data path:
  - rsX_data = 0 if rsX=0.
  - Otherwise, if BYPASS_EN and wb_valid and wb_rd==rsX, rsX_data = wb_data.
  - Otherwise, rsX_data = regfile[rsX].
- Hazard, evaluated combinationally. Let clr(r) = BYPASS_EN AND wb_valid AND wb_rd==r. Hazard is asserted if any of:
  - uses_rs1 AND busy[rs1] AND NOT clr(rs1);
  - uses_rs2 AND busy[rs2] AND NOT clr(rs2);
  - writes_rd AND busy[rd] AND NOT clr(rd) (WAW).
- in_ready = (NOT out_valid OR out_ready) AND NOT hazard AND NOT flush.
- Accept occurs when in_valid AND in_ready. On the next edge:
  - the output register captures all decoded fields, both operand data values and writes_rd;
  - out_valid becomes 1.
- Consume without accept: when out_valid AND out_ready AND no accept, out_valid becomes 0 on the edge.
- Stability: while out_valid=1 and out_ready=0, all out_* outputs hold stable.
- Busy bits, per edge:
  - clear busy[wb_rd] if wb_valid;
  - then set busy[rd] if accept AND writes_rd.
  - When both target the same index, set wins.
  - busy[0] is constant 0.
- Flush, on the edge:
  - out_valid becomes 0 and all busy bits become 0;
  - no accept occurs that cycle;
  - out_* data fields may hold stale values.
- Throughput and latency:
  - with no hazards, one instruction per cycle;
  - latency from accept to out_valid is 1 cycle.
- BYPASS_EN=0: same-cycle writeback does not clear the hazard. The dependent instruction is accepted one cycle later and reads the written register-file value.

Test Plan:
- Reset then write-back:
  - Stimulus: hold reset=0, then release; wb x5=0x1234 while idle; then accept ADD x7,x5,x0 (0x000283B3).
  - Required: out_valid=1 one cycle later; out_rs1_data=0x1234; out_rs2_data=0; out_writes_rd=1; busy[7]=1.
- RAW stall with bypass:
  - Stimulus: ADDI x3,x0,1 accepted; next cycle ADD x4,x3,x3 presented.
  - Required: in_ready=0 until the cycle wb_valid=1, wb_rd=3, wb_data=0xAA.
  - Required: in that cycle the instruction is accepted with both operands 0xAA.
  - Repeat with BYPASS_EN=0: accept is one cycle later, operands still 0xAA.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1; present a non-dependent LUI x9.
  - Required: in_ready=0; out_* values unchanged over 3 cycles.
  - Required: raise out_ready; LUI is accepted the same cycle and appears the next cycle.
- x0 handling:
  - Stimulus: wb x0=0xFFFF; then ADDI x0,x0,5.
  - Required: rs1_data=0; out_writes_rd=0; no busy bit set; the following instruction reading x0 does not stall.
- Store/branch:
  - Stimulus: SW x2,0(x1) with busy[2]=1.
  - Required: stall until x2 is written back.
  - Required: after accept, out_writes_rd=0 and busy[rd field] is unchanged.
- Flush and reset mid-operation:
  - Stimulus: busy[3]=1 and out_valid=1; assert flush with wb x6 in the same cycle.
  - Required: next cycle out_valid=0, all busy bits 0, regfile[6] written.
  - Stimulus: assert reset asynchronously between clk edges.
  - Required: out_valid drops immediately.
